// File: rtl/uart_sys_pkg.sv
// Shared UART system definitions: command codes, frame header bytes and the
// RX decoder state encoding, used by both the RX frame decoder and the TX controller.
package uart_sys_pkg;

    localparam logic [7:0] HDR_WRITE   = 8'hAA;
    localparam logic [7:0] HDR_READ    = 8'hBB;
    localparam logic [7:0] HDR_ALU_OPS = 8'hCC;
    localparam logic [7:0] HDR_ALU     = 8'hDD;

    localparam int unsigned TMO_W = 16;

    typedef enum logic [2:0] {
        CMD_IDLE    = 3'b000,
        CMD_WRITE   = 3'b001,
        CMD_READ    = 3'b010,
        CMD_OPERAND = 3'b011,
        CMD_ALU     = 3'b100
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_ADDR  = 4'd1,
        ST_GET_DATA  = 4'd2,
        ST_GET_OPA   = 4'd3,
        ST_GET_OPB   = 4'd4,
        ST_GET_FUN   = 4'd5,
        ST_ISSUE_WR  = 4'd6,
        ST_ISSUE_RD  = 4'd7,
        ST_ISSUE_OPA = 4'd8,
        ST_ISSUE_OPB = 4'd9,
        ST_ISSUE_ALU = 4'd10
    } rxdec_state_e;

    function automatic logic is_header(input logic [7:0] b);
        return (b == HDR_WRITE) || (b == HDR_READ) ||
               (b == HDR_ALU_OPS) || (b == HDR_ALU);
    endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle counter: clears on every received byte, counts only while
// enabled, and saturates at TIMEOUT_CYC to flag an expired frame.
module frame_timeout_cnt
    import uart_sys_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYC = 16'd1000
) (
    input  logic TXCont_CLK,
    input  logic TXCont_RST,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: idle states keep the counter parked at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = {TMO_W{1'b0}};
        end else if (cnt_q != TIMEOUT_CYC) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge TXCont_CLK or negedge TXCont_RST) begin
        if (!TXCont_RST) begin
            cnt_q <= {TMO_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == TIMEOUT_CYC);

endmodule

// File: rtl/rx_frame_decoder.sv
// Decodes UART RX byte frames (write / read / ALU) into one-cycle commands for
// the TX controller, with error, overrun and inter-byte timeout aborts.
module rx_frame_decoder
    import uart_sys_pkg::*;
#(
    parameter logic [7:0]       OP_A_ADDR   = 8'h00,
    parameter logic [7:0]       OP_B_ADDR   = 8'h01,
    parameter logic [TMO_W-1:0] TIMEOUT_CYC = 16'd1000
) (
    input  logic       TXCont_CLK,
    input  logic       TXCont_RST,
    input  logic [7:0] RXDec_Pdata,
    input  logic       RXDec_Data_Valid,
    input  logic       RXDec_Par_Err,
    input  logic       RXDec_Stp_Err,
    input  logic       RXDec_Ctrl_Busy,
    output logic [2:0] RXDec_command,
    output logic [7:0] RXDec_Addr_Out,
    output logic [7:0] RXDec_Pdata_Out,
    output logic       RXDec_Frame_Err
);

    rxdec_state_e state_q, state_d;
    logic [7:0]   hdr_q, hdr_d;
    logic [7:0]   addr_q, addr_d;
    logic [7:0]   data_q, data_d;
    logic [7:0]   opa_q, opa_d;
    logic [7:0]   opb_q, opb_d;
    logic [3:0]   fun_q, fun_d;
    cmd_e         cmd_q, cmd_d;
    logic [7:0]   addr_out_q, addr_out_d;
    logic [7:0]   pdata_out_q, pdata_out_d;
    logic         ferr_q, ferr_d;

    logic byte_ok_s;
    logic byte_bad_s;
    logic in_get_s;
    logic timeout_s;

    assign byte_bad_s = RXDec_Data_Valid && (RXDec_Par_Err || RXDec_Stp_Err);
    assign byte_ok_s  = RXDec_Data_Valid && !RXDec_Par_Err && !RXDec_Stp_Err;
    assign in_get_s   = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA) ||
                        (state_q == ST_GET_OPA)  || (state_q == ST_GET_OPB)  ||
                        (state_q == ST_GET_FUN);

    frame_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .TXCont_CLK (TXCont_CLK),
        .TXCont_RST (TXCont_RST),
        .clr_i      (RXDec_Data_Valid),
        .en_i       (in_get_s),
        .expired_o  (timeout_s)
    );

    // Next-state, capture and command decode
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        fun_d       = fun_q;
        cmd_d       = CMD_IDLE;
        addr_out_d  = addr_out_q;
        pdata_out_d = pdata_out_q;
        ferr_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byte_bad_s) begin
                    ferr_d = 1'b1;
                end else if (byte_ok_s) begin
                    if (is_header(RXDec_Pdata)) begin
                        hdr_d = RXDec_Pdata;
                        case (RXDec_Pdata)
                            HDR_WRITE, HDR_READ: state_d = ST_GET_ADDR;
                            HDR_ALU_OPS:         state_d = ST_GET_OPA;
                            default:             state_d = ST_GET_FUN;
                        endcase
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // A good byte takes priority over a coincident timeout
            ST_GET_ADDR, ST_GET_DATA, ST_GET_OPA, ST_GET_OPB, ST_GET_FUN: begin
                if (byte_bad_s) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (byte_ok_s) begin
                    case (state_q)
                        ST_GET_ADDR: begin
                            addr_d  = RXDec_Pdata;
                            state_d = (hdr_q == HDR_READ) ? ST_ISSUE_RD : ST_GET_DATA;
                        end
                        ST_GET_DATA: begin
                            data_d  = RXDec_Pdata;
                            state_d = ST_ISSUE_WR;
                        end
                        ST_GET_OPA: begin
                            opa_d   = RXDec_Pdata;
                            state_d = ST_GET_OPB;
                        end
                        ST_GET_OPB: begin
                            opb_d   = RXDec_Pdata;
                            state_d = ST_GET_FUN;
                        end
                        default: begin
                            fun_d   = RXDec_Pdata[3:0];
                            state_d = (hdr_q == HDR_ALU_OPS) ? ST_ISSUE_OPA : ST_ISSUE_ALU;
                        end
                    endcase
                end else if (timeout_s) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end

            ST_ISSUE_WR, ST_ISSUE_RD, ST_ISSUE_OPA, ST_ISSUE_OPB, ST_ISSUE_ALU: begin
                // Any byte landing here is an overrun; the pending issue proceeds
                ferr_d = RXDec_Data_Valid;
                if (!RXDec_Ctrl_Busy || (state_q == ST_ISSUE_OPB)) begin
                    case (state_q)
                        ST_ISSUE_WR: begin
                            cmd_d       = CMD_WRITE;
                            addr_out_d  = addr_q;
                            pdata_out_d = data_q;
                            state_d     = ST_IDLE;
                        end
                        ST_ISSUE_RD: begin
                            cmd_d       = CMD_READ;
                            addr_out_d  = addr_q;
                            pdata_out_d = 8'h00;
                            state_d     = ST_IDLE;
                        end
                        ST_ISSUE_OPA: begin
                            cmd_d       = CMD_OPERAND;
                            addr_out_d  = OP_A_ADDR;
                            pdata_out_d = opa_q;
                            state_d     = ST_ISSUE_OPB;
                        end
                        ST_ISSUE_OPB: begin
                            cmd_d       = CMD_OPERAND;
                            addr_out_d  = OP_B_ADDR;
                            pdata_out_d = opb_q;
                            state_d     = ST_ISSUE_ALU;
                        end
                        default: begin
                            cmd_d       = CMD_ALU;
                            addr_out_d  = 8'h00;
                            pdata_out_d = {4'b0000, fun_q};
                            state_d     = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured frame fields and registered outputs
    always_ff @(posedge TXCont_CLK or negedge TXCont_RST) begin
        if (!TXCont_RST) begin
            state_q     <= ST_IDLE;
            hdr_q       <= 8'h00;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            opa_q       <= 8'h00;
            opb_q       <= 8'h00;
            fun_q       <= 4'h0;
            cmd_q       <= CMD_IDLE;
            addr_out_q  <= 8'h00;
            pdata_out_q <= 8'h00;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            fun_q       <= fun_d;
            cmd_q       <= cmd_d;
            addr_out_q  <= addr_out_d;
            pdata_out_q <= pdata_out_d;
            ferr_q      <= ferr_d;
        end
    end

    assign RXDec_command   = cmd_q;
    assign RXDec_Addr_Out  = addr_out_q;
    assign RXDec_Pdata_Out = pdata_out_q;
    assign RXDec_Frame_Err = ferr_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder: frames, busy stalls, errors, overrun,
// inter-byte timeout and reset, with hand-computed expected outputs.
module tb_rx_frame_decoder;

    localparam logic [15:0] TMO = 16'd50;

    logic       clk;
    logic       rst_n;
    logic [7:0] pdata;
    logic       valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;
    logic [2:0] cmd;
    logic [7:0] addr_out;
    logic [7:0] pdata_out;
    logic       frame_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int ferr_cnt     = 0;

    rx_frame_decoder #(
        .OP_A_ADDR   (8'h00),
        .OP_B_ADDR   (8'h01),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .TXCont_CLK       (clk),
        .TXCont_RST       (rst_n),
        .RXDec_Pdata      (pdata),
        .RXDec_Data_Valid (valid),
        .RXDec_Par_Err    (par_err),
        .RXDec_Stp_Err    (stp_err),
        .RXDec_Ctrl_Busy  (busy),
        .RXDec_command    (cmd),
        .RXDec_Addr_Out   (addr_out),
        .RXDec_Pdata_Out  (pdata_out),
        .RXDec_Frame_Err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count Frame_Err pulses just after each rising edge
    always @(posedge clk) begin
        #1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe, input logic se);
        @(negedge clk);
        pdata   = b;
        valid   = 1'b1;
        par_err = pe;
        stp_err = se;
        @(negedge clk);
        valid   = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] c,
                              input logic [7:0] a, input logic [7:0] d);
        check({tag, "_cmd"}, {29'd0, cmd}, {29'd0, c});
        check({tag, "_addr"}, {24'd0, addr_out}, {24'd0, a});
        check({tag, "_pdata"}, {24'd0, pdata_out}, {24'd0, d});
    endtask

    initial begin
        int f0;
        int waited;
        rst_n   = 1'b0;
        pdata   = 8'h00;
        valid   = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
        busy    = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset", 3'b000, 8'h00, 8'h00);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write frame
        f0 = ferr_cnt;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        check("wr_pre", {29'd0, cmd}, 32'd0);
        @(negedge clk);
        expect_out("wr", 3'b001, 8'h05, 8'h3C);
        @(negedge clk);
        expect_out("wr_post", 3'b000, 8'h05, 8'h3C);
        check("wr_noerr", ferr_cnt - f0, 32'd0);

        // Read frame stalled by busy
        busy = 1'b1;
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'h07, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("rd_busy", {29'd0, cmd}, 32'd0);
            @(negedge clk);
        end
        busy = 1'b0;
        @(negedge clk);
        expect_out("rd", 3'b010, 8'h07, 8'h00);
        @(negedge clk);
        check("rd_post", {29'd0, cmd}, 32'd0);

        // ALU frame with operands
        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("alu_opa", 3'b011, 8'h00, 8'h12);
        @(negedge clk);
        expect_out("alu_opb", 3'b011, 8'h01, 8'h34);
        @(negedge clk);
        expect_out("alu_fun", 3'b100, 8'h00, 8'h01);
        @(negedge clk);
        check("alu_post", {29'd0, cmd}, 32'd0);

        // Parity error byte, then ALU-only frame
        f0 = ferr_cnt;
        send_byte(8'hAA, 1'b1, 1'b0);
        check("par_ferr", ferr_cnt - f0, 32'd1);
        send_byte(8'hDD, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("dd", 3'b100, 8'h00, 8'h02);
        check("dd_ferr", ferr_cnt - f0, 32'd1);

        // Stop-bit error mid-frame aborts; next header accepted fresh
        f0 = ferr_cnt;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h09, 1'b0, 1'b1);
        check("stp_ferr", ferr_cnt - f0, 32'd1);
        send_byte(8'hDD, 1'b0, 1'b0);
        send_byte(8'hF7, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("stp_dd", 3'b100, 8'h00, 8'h07);

        // Overrun while an issue is stalled
        busy = 1'b1;
        send_byte(8'hDD, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        f0 = ferr_cnt;
        send_byte(8'h77, 1'b0, 1'b0);
        check("ovr_ferr", ferr_cnt - f0, 32'd1);
        check("ovr_cmd", {29'd0, cmd}, 32'd0);
        busy = 1'b0;
        @(negedge clk);
        expect_out("ovr_alu", 3'b100, 8'h00, 8'h05);

        // Gap shorter than the timeout is tolerated
        f0 = ferr_cnt;
        send_byte(8'hAA, 1'b0, 1'b0);
        repeat (45) @(negedge clk);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("gap_wr", 3'b001, 8'h05, 8'h3C);
        check("gap_noerr", ferr_cnt - f0, 32'd0);

        // Timeout: abort one clock after the counter reaches TMO
        f0 = ferr_cnt;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        waited = 0;
        while (ferr_cnt == f0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("to_latency", waited, 32'd51);
        f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0, 1'b0);
        check("to_hdr_rej", ferr_cnt - f0, 32'd1);
        repeat (2) @(negedge clk);
        check("to_nocmd", {29'd0, cmd}, 32'd0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("to_rd", 3'b010, 8'h0A, 8'h00);

        // Reset mid-frame
        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_out("rst_mid", 3'b000, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_quiet", {29'd0, cmd}, 32'd0);
        end
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'h09, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("rst_rd", 3'b010, 8'h09, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_rd_post", {29'd0, cmd}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
